// File: rtl/icache_pkg.sv
// Shared state encodings and address-field helpers for the instruction cache.
package icache_pkg;

  localparam int unsigned ST_W = 3;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_WAIT = 3'd3;
  localparam logic [2:0] S_RESPOND   = 3'd4;

  // Width of an address field selecting one of n items (0 when n == 1).
  function automatic int unsigned field_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of a register holding an index into n items (never below 1).
  function automatic int unsigned reg_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Extract w bits starting at lsb; a zero-width field yields 0.
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and line storage with a single write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int unsigned SETS   = 4,
  parameter int unsigned IDX_W  = 2,
  parameter int unsigned TAG_W  = 27,
  parameter int unsigned LINE_W = 64
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [LINE_W-1:0] i_wline,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [LINE_W-1:0] o_line
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_line [SETS];

  // Valid bits: cleared by reset or flush, set when a line is filled.
  always_ff @(posedge clk) begin
    if (i_reset || i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  // Tag and data storage need no reset; valid qualifies them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_line[i_widx] <= i_wline;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_line  = r_line[i_ridx];

endmodule

// File: rtl/set_assoc_icache.sv
// N-way set-associative instruction cache with round-robin replacement and miss fill.
module set_assoc_icache
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 4,
  parameter int unsigned LINE_WORDS = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         req_ready,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_hit,
  input  logic                         flush,
  output logic                         mem_req_valid,
  output logic [ADDR_W-1:0]            mem_req_addr,
  input  logic                         mem_req_ready,
  input  logic                         mem_rsp_valid,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_rsp_data,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count
);

  localparam int unsigned OFF_W  = field_bits(LINE_WORDS);
  localparam int unsigned IDX_W  = field_bits(SETS);
  localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int unsigned WO_W   = reg_bits(LINE_WORDS);
  localparam int unsigned WAY_W  = reg_bits(WAYS);
  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;

  logic [ST_W-1:0]   r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_hit_count, r_miss_count;
  logic [DATA_W-1:0] r_fill_word;
  logic [WAY_W-1:0]  r_rr [SETS];

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [WO_W-1:0]   w_off;
  logic [ADDR_W-1:0] w_line_addr;
  logic [WAYS-1:0]   w_rd_valid, w_hit_vec, w_we;
  logic [TAG_W-1:0]  w_rd_tag  [WAYS];
  logic [LINE_W-1:0] w_rd_line [WAYS];
  logic [LINE_W-1:0] w_hit_line;
  logic [DATA_W-1:0] w_hit_word, w_fill_word;
  logic [WAY_W-1:0]  w_victim, w_rr_next;
  logic              w_hit, w_hit_rsp, w_accept, w_flush, w_fill_we, w_found;

  // Fields of the latched request address.
  assign w_off       = WO_W'(addr_field(64'(r_addr), 2, OFF_W));
  assign w_idx       = IDX_W'(addr_field(64'(r_addr), 2 + OFF_W, IDX_W));
  assign w_tag       = TAG_W'(addr_field(64'(r_addr), 2 + OFF_W + IDX_W, TAG_W));
  assign w_line_addr = r_addr & ~ADDR_W'((64'd1 << (2 + OFF_W)) - 64'd1);

  // Way storage and per-way tag compare.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit_vec[g] = w_rd_valid[g] && (w_rd_tag[g] == w_tag);
    assign w_we[g]      = w_fill_we && (w_victim == WAY_W'(g));
    icache_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)
    ) u_way (
      .clk(clk), .i_reset(reset), .i_flush(w_flush), .i_we(w_we[g]),
      .i_widx(w_idx), .i_wtag(w_tag), .i_wline(mem_rsp_data), .i_ridx(w_idx),
      .o_valid(w_rd_valid[g]), .o_tag(w_rd_tag[g]), .o_line(w_rd_line[g])
    );
  end

  // Select the hitting way's line; at most one way can match.
  always_comb begin
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit_vec[w]) w_hit_line = w_hit_line | w_rd_line[w];
    end
  end

  assign w_hit       = |w_hit_vec;
  assign w_hit_word  = w_hit_line[int'(w_off) * DATA_W +: DATA_W];
  assign w_fill_word = mem_rsp_data[int'(w_off) * DATA_W +: DATA_W];

  // Victim: lowest invalid way, else the set's round-robin pointer.
  always_comb begin
    w_victim = r_rr[w_idx];
    w_found  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_rd_valid[w]) begin
        w_victim = WAY_W'(w);
        w_found  = 1'b1;
      end
    end
  end

  assign w_rr_next = WAY_W'((32'(r_rr[w_idx]) + 32'd1) % WAYS);

  // Handshake and state-decoded outputs.
  assign req_ready     = !reset && (r_state == S_IDLE) && !flush;
  assign w_accept      = req_valid && req_ready;
  assign w_flush       = (r_state == S_IDLE) && flush;
  assign w_fill_we     = !reset && (r_state == S_FILL_WAIT) && mem_rsp_valid;
  assign w_hit_rsp     = !reset && (r_state == S_LOOKUP) && w_hit;
  assign rsp_valid     = w_hit_rsp || (!reset && (r_state == S_RESPOND));
  assign rsp_hit       = w_hit_rsp;
  assign rsp_data      = w_hit_rsp ? w_hit_word : (rsp_valid ? r_fill_word : '0);
  assign mem_req_valid = !reset && (r_state == S_FILL_REQ);
  assign mem_req_addr  = mem_req_valid ? w_line_addr : '0;
  assign hit_count     = r_hit_count;
  assign miss_count    = r_miss_count;

  // Next-state logic for lookup and miss fill.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP:    w_next = w_hit ? S_IDLE : S_FILL_REQ;
      S_FILL_REQ:  if (mem_req_ready) w_next = S_FILL_WAIT;
      S_FILL_WAIT: if (mem_rsp_valid) w_next = S_RESPOND;
      S_RESPOND:   w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State, request latch, statistics and replacement pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_fill_word  <= '0;
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_addr <= req_addr;
      if (r_state == S_LOOKUP) begin
        if (w_hit && (r_hit_count != '1))   r_hit_count  <= r_hit_count + CNT_W'(1);
        if (!w_hit && (r_miss_count != '1)) r_miss_count <= r_miss_count + CNT_W'(1);
      end
      if (w_fill_we) begin
        r_fill_word <= w_fill_word;
        if (!w_found) r_rr[w_idx] <= w_rr_next;
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_icache.sv
// Self-checking bench: vector tables plus hand sequences, responses checked via scoreboard.
module tb_set_assoc_icache;

  logic        clk, reset, req_valid, flush;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, rsp_hit;
  logic [31:0] rsp_data;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_rsp_data;
  logic [31:0] hit_count, miss_count;

  logic        req_ready2, rsp_valid2, rsp_hit2, mem_req_valid2;
  logic [31:0] rsp_data2, mem_req_addr2;
  logic [1:0]  hit_count2, miss_count2;

  set_assoc_icache dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter instance sharing all stimulus, used for saturation.
  set_assoc_icache #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .rsp_hit(rsp_hit2),
    .flush(flush), .mem_req_valid(mem_req_valid2), .mem_req_addr(mem_req_addr2),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .hit_count(hit_count2), .miss_count(miss_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic hit; int lat; } exp_t;
  typedef struct { logic [31:0] addr; logic hit; int lat; } vec_t;

  exp_t sb[$];
  int n_pass = 0, n_total = 0;
  int cyc_n = 0, acc_cyc = 0, n_memreq = 0;
  logic acc_flag = 1'b0;
  logic [31:0] exp_fill = '0;
  logic pend = 1'b0;
  int pend_cnt = 0, rsp_delay = 0, stall = 0;
  logic [31:0] pend_addr = '0;
  logic s_req_ready, s_rsp_valid, s_rsp_hit, s_mem_req_valid;
  logic [31:0] s_rsp_data, s_mem_req_addr;

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] wi;
    wi = a >> 2;
    return (wi[0] ? 32'hBBBB0000 : 32'hAAAA0000) | {16'h0, wi[15:0]};
  endfunction

  function automatic logic [63:0] mline(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h7;
    return {mword(b + 32'd4), mword(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: sample at negedge, then drive memory-side inputs just after posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_hit = rsp_hit;
    s_rsp_data = rsp_data; s_mem_req_valid = mem_req_valid; s_mem_req_addr = mem_req_addr;
    if (req_valid && req_ready) begin acc_flag = 1'b1; acc_cyc = cyc_n; end
    if (mem_req_valid) begin
      n_memreq++;
      chk("mem_req_addr", mem_req_addr, exp_fill);
      if (mem_req_ready) begin pend = 1'b1; pend_cnt = rsp_delay; pend_addr = mem_req_addr; end
      else if (stall > 0) stall--;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 data=0x%0h expected no response", rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_hit", rsp_hit, e.hit);
        chk("rsp_latency", cyc_n - acc_cyc, e.lat);
      end
    end
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin mem_rsp_valid = 1'b1; mem_rsp_data = mline(pend_addr); pend = 1'b0; end
      else pend_cnt--;
    end
    mem_req_ready = (stall == 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 60) begin cyc(); n++; end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL rsp_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input logic [31:0] a, input logic h, input int lat);
    exp_t e;
    int n = 0;
    e.data = mword(a & ~32'h3); e.hit = h; e.lat = lat;
    sb.push_back(e);
    exp_fill = a & ~32'h7;
    req_valid = 1'b1; req_addr = a; acc_flag = 1'b0;
    while (!acc_flag && n < 20) begin cyc(); n++; end
    req_valid = 1'b0;
    if (!acc_flag) begin
      n_total++;
      $display("FAIL accept_timeout: got no acceptance of 0x%0h expected one", a);
      sb.delete();
    end else drain();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; sb.delete();
    pend = 1'b0; stall = 0; rsp_delay = 0; mem_req_ready = 1'b1;
    cyc();
    cyc();
    chk("req_ready_in_reset", s_req_ready, 0);
    reset = 1'b0;
  endtask

  vec_t t1[11];
  vec_t t2[7];

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

    t1 = '{'{32'h00, 1'b0, 4}, '{32'h04, 1'b1, 1}, '{32'h20, 1'b0, 4}, '{32'h40, 1'b0, 4},
           '{32'h20, 1'b1, 1}, '{32'h00, 1'b0, 4}, '{32'h44, 1'b1, 1}, '{32'h24, 1'b0, 4},
           '{32'h04, 1'b1, 1}, '{32'h08, 1'b0, 4}, '{32'h0C, 1'b1, 1}};
    t2 = '{'{32'h00, 1'b0, 4}, '{32'h04, 1'b1, 1}, '{32'h20, 1'b0, 4}, '{32'h24, 1'b1, 1},
           '{32'h40, 1'b0, 4}, '{32'h60, 1'b0, 4}, '{32'h88, 1'b0, 4}};

    // Reset state
    do_reset();
    cyc();
    chk("rst_req_ready", s_req_ready, 1);
    chk("rst_rsp_valid", s_rsp_valid, 0);
    chk("rst_rsp_hit", s_rsp_hit, 0);
    chk("rst_rsp_data", s_rsp_data, 0);
    chk("rst_mem_req_valid", s_mem_req_valid, 0);
    chk("rst_mem_req_addr", s_mem_req_addr, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);

    // Fill, hit and set-0 conflict replacement
    for (int i = 0; i < 11; i++) send(t1[i].addr, t1[i].hit, t1[i].lat);
    chk("t1_hit_count", hit_count, 5);
    chk("t1_miss_count", miss_count, 6);
    chk("t1_hit_count_sat", hit_count2, 3);
    chk("t1_miss_count_sat", miss_count2, 3);

    // Memory not ready for 5 cycles
    stall = 5; mem_req_ready = 1'b0; n_memreq = 0;
    send(32'hA0, 1'b0, 9);
    chk("stall_memreq_cycles", n_memreq, 6);
    chk("stall_miss_count", miss_count, 7);

    // Flush then re-read a resident line
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    send(32'h20, 1'b0, 4);

    // Flush and request in the same cycle
    begin
      exp_t e;
      e.data = mword(32'h04); e.hit = 1'b0; e.lat = 4;
      sb.push_back(e);
      exp_fill = 32'h00;
      flush = 1'b1; req_valid = 1'b1; req_addr = 32'h04; acc_flag = 1'b0;
      cyc();
      chk("flush_req_ready", s_req_ready, 0);
      chk("flush_no_accept", acc_flag, 0);
      flush = 1'b0;
      cyc();
      chk("accept_after_flush", acc_flag, 1);
      req_valid = 1'b0;
      drain();
    end

    // Counter sequence from reset, then saturation of the 2-bit counter
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send(t2[i].addr, t2[i].hit, t2[i].lat);
      if (i == 4) begin
        chk("seq_miss_count", miss_count, 3);
        chk("seq_hit_count", hit_count, 2);
      end
    end
    chk("seq_miss_count_final", miss_count, 5);
    chk("sat_miss_count", miss_count2, 3);
    chk("sat_hit_count", hit_count2, 2);

    // Reset during FILL_WAIT abandons the fill
    do_reset();
    rsp_delay = 3; exp_fill = 32'h00;
    req_valid = 1'b1; req_addr = 32'h00; acc_flag = 1'b0;
    cyc();
    chk("rf_accept", acc_flag, 1);
    req_valid = 1'b0;
    cyc();
    cyc();
    chk("rf_fill_issued", pend, 1);
    reset = 1'b1;
    cyc();
    chk("rf_req_ready_in_reset", s_req_ready, 0);
    reset = 1'b0;
    cyc();
    chk("rf_req_ready_after", s_req_ready, 1);
    chk("rf_mem_req_valid", s_mem_req_valid, 0);
    chk("rf_rsp_valid", s_rsp_valid, 0);
    repeat (6) cyc();
    rsp_delay = 0;
    send(32'h00, 1'b0, 4);
    chk("rf_miss_count", miss_count, 1);
    chk("rf_hit_count", hit_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule
